// File: rtl/z80bd_pkg.sv
`timescale 1ns/1ps
// z80bd_pkg: shared constants, FSM state type and small priority helpers for
// the z80bd CPLD (bus decoder / memory mapper / interrupt controller).
package z80bd_pkg;

  // Existing memory-mapper I/O ports.
  localparam logic [7:0] PORT_MAP0    = 8'h10;
  localparam logic [7:0] PORT_MAP1    = 8'h11;
  localparam logic [7:0] PORT_MAP2    = 8'h12;
  localparam logic [7:0] PORT_MAP3    = 8'h13;

  // Interrupt controller I/O ports.
  localparam logic [7:0] PORT_IC_MASK = 8'h14;
  localparam logic [7:0] PORT_IC_STAT = 8'h15;
  localparam logic [7:0] PORT_IC_VEC  = 8'h16;

  // Number of interrupt sources: 0 = frame timer, 1..3 = IRQ_IN[0..2].
  localparam int N_SRC = 4;

  // RETI is the two-byte opcode ED 4D.
  localparam logic [7:0] RETI_OP1 = 8'hED;
  localparam logic [7:0] RETI_OP2 = 8'h4D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } ic_state_e;

  // Index of the lowest set bit (lowest index = highest priority); 0 if none.
  function automatic logic [1:0] lowest_idx(input logic [N_SRC-1:0] v);
    lowest_idx = 2'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_idx = 2'(i);
      end else begin
        lowest_idx = lowest_idx;
      end
    end
  endfunction

  // All sources at or below the priority of the highest-priority set bit.
  function automatic logic [N_SRC-1:0] at_or_below(input logic [N_SRC-1:0] v);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      seen           = seen | v[i];
      at_or_below[i] = seen;
    end
  endfunction

  // Clear the lowest (highest-priority) set bit.
  function automatic logic [N_SRC-1:0] clear_lowest(input logic [N_SRC-1:0] v);
    clear_lowest = v & (v - 4'd1);
  endfunction

endpackage

// File: rtl/z80_int_ctrl_if.sv
`timescale 1ns/1ps
// z80_int_ctrl_if: Z80 bus strobes, address/data, IRQ inputs and INT output
// seen by the interrupt controller. master = CPU/board side, slave = controller.
interface z80_int_ctrl_if;
  logic       IORQ;
  logic       M1;
  logic       MREQ;
  logic       RD;
  logic       WR;
  logic [7:0] A;
  logic [7:0] D_IN;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic [2:0] IRQ_IN;
  logic       INT_N;

  modport master (
    output IORQ, M1, MREQ, RD, WR, A, D_IN, IRQ_IN,
    input  D_OUT, D_OE, INT_N
  );

  modport slave (
    input  IORQ, M1, MREQ, RD, WR, A, D_IN, IRQ_IN,
    output D_OUT, D_OE, INT_N
  );
endinterface

// File: rtl/z80_bus_sync.sv
`timescale 1ns/1ps
// z80_bus_sync: 2-FF synchroniser for asynchronous bus signals plus a
// one-cycle falling-edge pulse derived from the synchronised value.
module z80_bus_sync #(
  parameter int W       = 1,
  parameter bit RST_VAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] fall_o
);
  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;
  logic [W-1:0] prev_d, prev_q;

  // Next values of the synchroniser chain and the edge-history stage.
  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Chain flops; reset to the idle level so no edge is seen out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= {W{RST_VAL}};
      sync_q <= {W{RST_VAL}};
      prev_q <= {W{RST_VAL}};
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;
endmodule

// File: rtl/z80_int_ctrl.sv
`timescale 1ns/1ps
// z80_int_ctrl: Z80 mode-2 interrupt controller. Four sources (frame timer +
// three level IRQs), lowest index wins, IM2 vector supplied during intack.
// Optional in-service nesting with RETI snooping: define Z80_INT_RETI_SNOOP_EN.
module z80_int_ctrl
  import z80bd_pkg::*;
#(
  parameter logic [7:0]  IC_MASK_PORT = PORT_IC_MASK,
  parameter logic [7:0]  IC_STAT_PORT = PORT_IC_STAT,
  parameter logic [7:0]  IC_VEC_PORT  = PORT_IC_VEC,
  parameter int unsigned TIMER_DIV    = 480000
) (
  input logic            CLK_24MHz,
  input logic            RST,
  z80_int_ctrl_if.slave  bus
);
  localparam logic [19:0] TMR_LAST = 20'(TIMER_DIV - 1);

  // Synchronised strobes: bit 0 IORQ, 1 M1, 2 MREQ, 3 RD, 4 WR.
  logic [4:0] stb_raw_s, stb_sync_s, stb_fall_s;
  logic [2:0] irq_sync_s, irq_fall_s;
  logic       iorq_s, m1_s, mreq_s, rd_s, wr_s;
  logic       io_wr_s, io_rd_s, intack_s;
  logic       io_wr_edge_s, intack_edge_s, ack_take_s, stat_clr_s, tmr_tick_s;
  logic [3:0] pend_s, active_s, blocked_s, in_service_s;
  logic [1:0] sel_s;
  logic       unused_s;

  logic [3:0]  mask_d, mask_q;
  logic        timer_en_d, timer_en_q;
  logic [4:0]  vec_base_d, vec_base_q;
  logic        tmr_pend_d, tmr_pend_q;
  logic [19:0] tmr_cnt_d, tmr_cnt_q;
  ic_state_e   state_d, state_q;
  logic [1:0]  ack_src_d, ack_src_q;
  logic        int_n_d, int_n_q;
  logic        d_oe_d, d_oe_q;
  logic [7:0]  d_out_d, d_out_q;

  assign stb_raw_s = {bus.WR, bus.RD, bus.MREQ, bus.M1, bus.IORQ};

  z80_bus_sync #(.W(5), .RST_VAL(1'b1)) u_stb_sync (
    .clk     (CLK_24MHz),
    .rst     (RST),
    .async_i (stb_raw_s),
    .sync_o  (stb_sync_s),
    .fall_o  (stb_fall_s)
  );

  z80_bus_sync #(.W(3), .RST_VAL(1'b0)) u_irq_sync (
    .clk     (CLK_24MHz),
    .rst     (RST),
    .async_i (bus.IRQ_IN),
    .sync_o  (irq_sync_s),
    .fall_o  (irq_fall_s)
  );

  assign iorq_s = stb_sync_s[0];
  assign m1_s   = stb_sync_s[1];
  assign mreq_s = stb_sync_s[2];
  assign rd_s   = stb_sync_s[3];
  assign wr_s   = stb_sync_s[4];

  // Decoded cycles; their start is the cycle in which one of the defining
  // strobes falls while the combination is true.
  assign io_wr_s       = !iorq_s && !wr_s && m1_s;
  assign io_rd_s       = !iorq_s && !rd_s && m1_s;
  assign intack_s      = !iorq_s && !m1_s;
  assign io_wr_edge_s  = io_wr_s && (stb_fall_s[0] || stb_fall_s[4]);
  assign intack_edge_s = intack_s && (stb_fall_s[0] || stb_fall_s[1]);

  assign pend_s     = {irq_sync_s, tmr_pend_q};
  assign active_s   = pend_s & mask_q & ~blocked_s;
  assign sel_s      = lowest_idx(active_s);
  assign ack_take_s = (state_q == REQ) && (active_s != 4'd0) && intack_edge_s;
  assign stat_clr_s = io_wr_edge_s && (bus.A == IC_STAT_PORT) && bus.D_IN[0];
  assign tmr_tick_s = timer_en_q && (tmr_cnt_q == TMR_LAST);

`ifdef Z80_INT_RETI_SNOOP_EN
  logic [3:0] isr_d, isr_q;
  logic       prefix_d, prefix_q;
  logic       fetch_s, fetch_edge_s;

  assign fetch_s      = !m1_s && !mreq_s && !rd_s;
  assign fetch_edge_s = fetch_s && (stb_fall_s[1] || stb_fall_s[2] || stb_fall_s[3]);
  assign in_service_s = isr_q;
  assign blocked_s    = at_or_below(isr_q);
  assign unused_s     = ^irq_fall_s;

  // RETI snooping (ED then 4D on consecutive fetches) and in-service tracking.
  always_comb begin
    isr_d    = isr_q;
    prefix_d = prefix_q;
    if (fetch_edge_s) begin
      prefix_d = (bus.D_IN == RETI_OP1);
      if (prefix_q && (bus.D_IN == RETI_OP2)) begin
        isr_d = clear_lowest(isr_q);
      end else begin
        isr_d = isr_q;
      end
    end else begin
      prefix_d = prefix_q;
    end
    if (ack_take_s) begin
      isr_d = isr_d | (4'b0001 << sel_s);
    end else begin
      isr_d = isr_d;
    end
  end

  // In-service and RETI-prefix state.
  always_ff @(posedge CLK_24MHz) begin
    if (RST) begin
      isr_q    <= 4'd0;
      prefix_q <= 1'b0;
    end else begin
      isr_q    <= isr_d;
      prefix_q <= prefix_d;
    end
  end
`else
  assign in_service_s = 4'd0;
  assign blocked_s    = 4'd0;
  assign unused_s     = ^{irq_fall_s, stb_fall_s[3:2], mreq_s};
`endif

  // Register writes from the CPU on the start of an I/O write cycle.
  always_comb begin
    mask_d     = mask_q;
    timer_en_d = timer_en_q;
    vec_base_d = vec_base_q;
    if (io_wr_edge_s && (bus.A == IC_MASK_PORT)) begin
      mask_d     = bus.D_IN[3:0];
      timer_en_d = bus.D_IN[7];
    end else if (io_wr_edge_s && (bus.A == IC_VEC_PORT)) begin
      vec_base_d = bus.D_IN[7:3];
    end else begin
      mask_d = mask_q;
    end
  end

  // Frame timer and its pending flag; a tick beats a same-cycle clear.
  always_comb begin
    if (!timer_en_q) begin
      tmr_cnt_d = 20'd0;
    end else if (tmr_tick_s) begin
      tmr_cnt_d = 20'd0;
    end else begin
      tmr_cnt_d = tmr_cnt_q + 20'd1;
    end
    tmr_pend_d = tmr_pend_q;
    if (stat_clr_s || (ack_take_s && (sel_s == 2'd0))) begin
      tmr_pend_d = 1'b0;
    end else begin
      tmr_pend_d = tmr_pend_q;
    end
    if (tmr_tick_s) begin
      tmr_pend_d = 1'b1;
    end else begin
      tmr_pend_d = tmr_pend_d;
    end
  end

  // Request/acknowledge sequencing.
  always_comb begin
    state_d   = state_q;
    ack_src_d = ack_src_q;
    case (state_q)
      IDLE: begin
        if (active_s != 4'd0) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (active_s == 4'd0) begin
          state_d = IDLE;
        end else if (ack_take_s) begin
          state_d   = ACK;
          ack_src_d = sel_s;
        end else begin
          state_d = REQ;
        end
      end
      ACK: begin
        if (!intack_s) begin
          state_d = GAP;
        end else begin
          state_d = ACK;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered bus outputs; intack outranks io reads.
  always_comb begin
    int_n_d = (state_d != REQ);
    d_oe_d  = 1'b0;
    d_out_d = 8'h00;
    if (state_d == ACK) begin
      d_oe_d  = 1'b1;
      d_out_d = {vec_base_q, ack_src_d, 1'b0};
    end else if (intack_s) begin
      if (state_q == IDLE) begin
        d_oe_d  = 1'b1;
        d_out_d = {vec_base_q, 2'b11, 1'b0};
      end else begin
        d_oe_d = 1'b0;
      end
    end else if (io_rd_s) begin
      case (bus.A)
        IC_MASK_PORT: begin
          d_oe_d  = 1'b1;
          d_out_d = {timer_en_q, 3'b000, mask_q};
        end
        IC_STAT_PORT: begin
          d_oe_d  = 1'b1;
          d_out_d = {in_service_s, pend_s};
        end
        IC_VEC_PORT: begin
          d_oe_d  = 1'b1;
          d_out_d = {vec_base_q, 3'b000};
        end
        default: begin
          d_oe_d  = 1'b0;
          d_out_d = 8'h00;
        end
      endcase
    end else begin
      d_oe_d = 1'b0;
    end
  end

  // All controller state, cleared by the synchronous reset.
  always_ff @(posedge CLK_24MHz) begin
    if (RST) begin
      mask_q     <= 4'd0;
      timer_en_q <= 1'b0;
      vec_base_q <= 5'd0;
      tmr_pend_q <= 1'b0;
      tmr_cnt_q  <= 20'd0;
      state_q    <= IDLE;
      ack_src_q  <= 2'd0;
      int_n_q    <= 1'b1;
      d_oe_q     <= 1'b0;
      d_out_q    <= 8'h00;
    end else begin
      mask_q     <= mask_d;
      timer_en_q <= timer_en_d;
      vec_base_q <= vec_base_d;
      tmr_pend_q <= tmr_pend_d;
      tmr_cnt_q  <= tmr_cnt_d;
      state_q    <= state_d;
      ack_src_q  <= ack_src_d;
      int_n_q    <= int_n_d;
      d_oe_q     <= d_oe_d;
      d_out_q    <= d_out_d;
    end
  end

  assign bus.INT_N = int_n_q;
  assign bus.D_OE  = d_oe_q;
  assign bus.D_OUT = d_out_q;
endmodule

// File: doc/z80_int_ctrl.md
Name: z80_int_ctrl

Overview:
- Z80 mode-2 interrupt controller sitting beside the bus decoder/memory mapper in the z80bd CPLD.
- Drives the CPU INT line, which the decoder leaves unused today.
- Collects four sources:
  - 0: internal frame timer.
  - 1..3: external level IRQs, with the 16550 U_INT on IRQ_IN[0].
- Supplies the IM2 vector during the interrupt-acknowledge cycle and exposes mask/status/vector registers in Z80 I/O space next to the mapper ports 0x10..0x13.

Parameters:
- IC_MASK_PORT, 8'h14, mask/control register I/O address (A[7:0]).
- IC_STAT_PORT, 8'h15, status register I/O address.
- IC_VEC_PORT, 8'h16, vector base register I/O address.
- TIMER_DIV, 480000, CLK_24MHz cycles per timer tick (50 Hz); legal range 2..2^20.

Ports:
- CLK_24MHz  in  1  system clock; the only clock.
- RST  in  1  reset, synchronous, active-high.
- IORQ  in  1  Z80 /IORQ, async, active-low.
- M1  in  1  Z80 /M1, async, active-low.
- MREQ  in  1  Z80 /MREQ, async, active-low.
- RD  in  1  Z80 /RD, async, active-low.
- WR  in  1  Z80 /WR, async, active-low.
- A  in  8  Z80 A[7:0].
- D_IN  in  8  Z80 data bus input.
- D_OUT  out  8  data driven to the bus.
- D_OE  out  1  high = top level drives D with D_OUT.
- IRQ_IN  in  3  external IRQs, async, active-high level.
- INT_N  out  1  to Z80 /INT, active-low.

Behaviour:
- Synchronisation:
  - IORQ, M1, MREQ, RD, WR and IRQ_IN pass through 2-FF synchronisers.
  - Strobe falling edges are detected on the synchronised values.
  - A and D_IN are sampled on the detected edge. The CPU clock is CLK_24MHz/16, so they are stable by then.
- Decoded cycles (synchronised):
  - io_wr = !IORQ & !WR & M1.
  - io_rd = !IORQ & !RD & M1.
  - intack = !IORQ & !M1.
- Registers, all cleared to 0 on RST:
  - mask[3:0].
  - timer_en (MASK bit7).
  - vec_base[7:3].
  - tmr_pend.
  - FSM state IDLE.
- Register writes, on the io_wr falling edge with matching A:
  - MASK: mask <= D[3:0], timer_en <= D[7].
  - STAT: D[0]=1 clears tmr_pend.
  - VEC: vec_base <= D[7:3].
- Register reads, while io_rd is active and A matches:
  - D_OE=1.
  - MASK reads {timer_en,3'b0,mask}.
  - STAT reads {in_service[3:0], pend[3:0]}. in_service reads 0 without the optional feature.
  - VEC reads {vec_base,3'b0}.
- pend = {IRQ_IN_sync[2:0], tmr_pend}.
- active = pend & mask & ~blocked.
- Priority: lowest index wins. sel = index of lowest set bit of active.
- Timer:
  - 20-bit counter, 0..TIMER_DIV-1. Held at 0 while timer_en=0.
  - At terminal count it sets tmr_pend and wraps.
  - A tick in the same cycle as a STAT clear wins: tmr_pend stays 1.
- FSM:
  - IDLE: INT_N=1. If active!=0, go to REQ.
  - REQ: INT_N=0.
    - sel is re-evaluated every cycle.
    - If active becomes 0 (mask write, level drop), go to IDLE and INT_N=1 next cycle.
    - On the intack falling edge, latch ack_src=sel and go to ACK.
  - ACK: INT_N=1, D_OE=1, D_OUT={vec_base, ack_src[1:0], 1'b0}.
    - Source 0 acknowledged clears tmr_pend in this cycle.
    - When intack goes inactive, go to GAP.
  - GAP: one cycle, INT_N=1, D_OE=0, then go to IDLE.
- intack seen in IDLE (spurious):
  - D_OE=1, vector of source 3.
  - No state change, pend unchanged.
- D_OE is never asserted by io_rd and intack simultaneously. intack has priority.
- RST mid-operation, including during ACK: next cycle INT_N=1, D_OE=0, all registers cleared, timer counter 0.
- Reset values of outputs: INT_N=1, D_OE=0, D_OUT=0.

Optional Feature:
- Macro: Z80_INT_RETI_SNOOP_EN.
- Defined:
  - On ACK, set in_service[ack_src].
  - blocked = sources at or below the highest-priority in-service level.
  - RETI is snooped as opcode fetches (!M1 & !MREQ & !RD falling edge) of 8'hED immediately followed by the next M1 fetch of 8'h4D. Any other second byte discards the prefix.
  - RETI clears the highest-priority in_service bit.
  - in_service=0 on RST.
- Undefined:
  - in_service is constant 0 and blocked=0.
  - INT may re-assert directly after GAP.

Decomposition:
- Package z80bd_pkg holds:
  - Port constants, both the existing mapper ports 8'h10..8'h13 and 8'h14..8'h16.
  - N_SRC=4.
  - FSM state enum {IDLE, REQ, ACK, GAP}.
  - RETI opcode constants 8'hED and 8'h4D.
- One sub-module, z80_bus_sync: 2-FF synchroniser plus falling-edge pulse.
  - Parameterised width, reset value 1 (idle-high strobes).
  - Instantiated for the strobes and for IRQ_IN (reset 0).

Test Plan:
- Reset then write MASK=8'h81, TIMER_DIV=100 in bench:
  - INT_N falls within 103 cycles.
  - IM2 ack (M1+IORQ low) gives D_OE=1, D_OUT=8'h00.
  - tmr_pend clears; STAT reads 8'h00.
- VEC=8'hA8, MASK=8'h0E, IRQ_IN=3'b110:
  - Ack vector 8'hAC (source 2).
  - Drop IRQ_IN[1], second ack gives 8'hAE.
- MASK=8'h02, IRQ_IN[0]=1 → INT_N=0. Write MASK=8'h00 → INT_N=1 within 4 cycles of the WR edge; no ack expected.
- STAT write 8'h01 in the exact cycle of a timer tick → STAT read shows bit0=1.
- Assert RST during ACK → next cycle INT_N=1, D_OE=0, MASK reads 8'h00.
- With Z80_INT_RETI_SNOOP_EN:
  - Ack source 1, then raise IRQ_IN[2] → INT_N stays 1.
  - Fetch ED,4D → INT_N falls, ack vector {vec_base,2'b11,0}.
  - Fetch ED,00 → no unblock.
